// File: rtl/axi_pkg.sv
// Shared state encoding, AXI constants and default widths for the FIFO-to-AXI write bridge.
package axi_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] STRB_ALL   = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AW    = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    BRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_wb_if.sv
// Bundles the FIFO, burst-parameter RAM and AXI write channels of the bridge.
interface axi_wb_if
  import axi_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic [DATA_W-1:0] arg_0_out_data;
  logic              arg_0_read_ready;
  logic              arg_0_read_valid;

  logic [7:0]        arg_1_raddr;
  logic [LEN_W-1:0]  arg_1_rdata;
  logic [15:0]       arg_2_raddr;
  logic [ADDR_W-1:0] arg_2_rdata;

  logic [ADDR_W-1:0] arg_3_s_axi_awaddr;
  logic [LEN_W-1:0]  arg_3_s_axi_awlen;
  logic [2:0]        arg_3_s_axi_awsize;
  logic [1:0]        arg_3_s_axi_awburst;
  logic              arg_3_s_axi_awvalid;
  logic              arg_3_s_axi_awready;

  logic [DATA_W-1:0] arg_3_s_axi_wdata;
  logic [3:0]        arg_3_s_axi_wstrb;
  logic              arg_3_s_axi_wlast;
  logic              arg_3_s_axi_wvalid;
  logic              arg_3_s_axi_wready;

  logic              arg_3_s_axi_bready;
  logic              arg_3_s_axi_bvalid;
  logic [1:0]        arg_3_s_axi_bresp;

  logic              valid;
  logic              error;

  modport master (
    input  arg_0_out_data, arg_0_read_ready,
    output arg_0_read_valid,
    output arg_1_raddr, arg_2_raddr,
    input  arg_1_rdata, arg_2_rdata,
    output arg_3_s_axi_awaddr, arg_3_s_axi_awlen, arg_3_s_axi_awsize,
    output arg_3_s_axi_awburst, arg_3_s_axi_awvalid,
    input  arg_3_s_axi_awready,
    output arg_3_s_axi_wdata, arg_3_s_axi_wstrb, arg_3_s_axi_wlast, arg_3_s_axi_wvalid,
    input  arg_3_s_axi_wready,
    output arg_3_s_axi_bready,
    input  arg_3_s_axi_bvalid, arg_3_s_axi_bresp,
    output valid, error
  );

  modport slave (
    output arg_0_out_data, arg_0_read_ready,
    input  arg_0_read_valid,
    input  arg_1_raddr, arg_2_raddr,
    output arg_1_rdata, arg_2_rdata,
    input  arg_3_s_axi_awaddr, arg_3_s_axi_awlen, arg_3_s_axi_awsize,
    input  arg_3_s_axi_awburst, arg_3_s_axi_awvalid,
    output arg_3_s_axi_awready,
    input  arg_3_s_axi_wdata, arg_3_s_axi_wstrb, arg_3_s_axi_wlast, arg_3_s_axi_wvalid,
    output arg_3_s_axi_wready,
    input  arg_3_s_axi_bready,
    output arg_3_s_axi_bvalid, arg_3_s_axi_bresp,
    input  valid, error
  );

endinterface

// File: rtl/axi_wbeat.sv
// Write-data beat path: beat counter, latched FIFO word and wlast generation.
// Data outputs are forced to zero outside SEND so nothing stale ever reaches the bus.
module axi_wbeat
  import axi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_pop,
  input  logic              i_adv,
  input  logic              i_send,
  input  logic [DATA_W-1:0] i_dat,
  input  logic [LEN_W-1:0]  i_len,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_wlast,
  output logic              o_last
);

  // One extra bit so a 256-beat burst never wraps the count.
  logic [LEN_W:0]    r_cnt;
  logic [DATA_W-1:0] r_wdata;
  logic              w_last;

  assign w_last = (r_cnt == {1'b0, i_len});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_wdata <= '0;
    end else begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_adv) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_clr) begin
        r_wdata <= '0;
      end else if (i_pop) begin
        r_wdata <= i_dat;
      end
    end
  end

  assign o_last  = w_last;
  assign o_wlast = i_send && w_last;
  assign o_wdata = i_send ? r_wdata : '0;
  assign o_wstrb = i_send ? STRB_ALL : 4'h0;

endmodule

// File: rtl/axi_wb.sv
// FIFO-to-AXI4 write bridge: one INCR burst of len+1 FIFO words, then capture the write response.
// Each beat costs a FETCH (pop) and a SEND cycle; every channel stalls indefinitely on its handshake.
module axi_wb
  import axi_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic     clk,
  input  logic     rst,
  axi_wb_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_base;
  logic              r_error;

  logic              w_pop;
  logic              w_w_hs;
  logic              w_adv;
  logic              w_beat_last;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_wstrb;
  logic              w_wlast;

  assign w_pop  = (r_state == FETCH) && bus.arg_0_read_ready;
  assign w_w_hs = (r_state == SEND) && bus.arg_3_s_axi_wready;
  assign w_adv  = w_w_hs && !w_beat_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = AW;
      AW:      if (bus.arg_3_s_axi_awready) w_next = FETCH;
      FETCH:   if (w_pop) w_next = SEND;
      SEND:    if (w_w_hs) w_next = w_beat_last ? BRESP : FETCH;
      BRESP:   if (bus.arg_3_s_axi_bvalid) w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.arg_3_s_axi_awvalid = 1'b0;
    bus.arg_3_s_axi_awaddr  = '0;
    bus.arg_3_s_axi_awlen   = '0;
    bus.arg_3_s_axi_awsize  = 3'd0;
    bus.arg_3_s_axi_awburst = 2'b00;
    bus.arg_3_s_axi_wvalid  = 1'b0;
    bus.arg_3_s_axi_bready  = 1'b0;
    bus.arg_0_read_valid    = 1'b0;
    bus.valid               = 1'b0;
    case (r_state)
      AW: begin
        bus.arg_3_s_axi_awvalid = 1'b1;
        bus.arg_3_s_axi_awaddr  = r_base;
        bus.arg_3_s_axi_awlen   = r_len;
        bus.arg_3_s_axi_awsize  = SIZE_4B;
        bus.arg_3_s_axi_awburst = BURST_INCR;
      end
      FETCH:   bus.arg_0_read_valid   = bus.arg_0_read_ready;
      SEND:    bus.arg_3_s_axi_wvalid = 1'b1;
      BRESP:   bus.arg_3_s_axi_bready = 1'b1;
      DONE:    bus.valid              = 1'b1;
      default: ;
    endcase
  end

  // Burst parameters are sampled once per run, while the FSM sits in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_base  <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_len  <= bus.arg_1_rdata;
        r_base <= bus.arg_2_rdata;
      end
      if ((r_state == BRESP) && bus.arg_3_s_axi_bvalid) begin
        r_error <= resp_is_err(bus.arg_3_s_axi_bresp);
      end
    end
  end

  axi_wbeat #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_wbeat (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == IDLE),
    .i_pop   (w_pop),
    .i_adv   (w_adv),
    .i_send  (r_state == SEND),
    .i_dat   (bus.arg_0_out_data),
    .i_len   (r_len),
    .o_wdata (w_wdata),
    .o_wstrb (w_wstrb),
    .o_wlast (w_wlast),
    .o_last  (w_beat_last)
  );

  assign bus.arg_3_s_axi_wdata = w_wdata;
  assign bus.arg_3_s_axi_wstrb = w_wstrb;
  assign bus.arg_3_s_axi_wlast = w_wlast;
  assign bus.arg_1_raddr       = 8'd0;
  assign bus.arg_2_raddr       = 16'd0;
  assign bus.error             = r_error;

endmodule

// File: tb/tb_axi_wb.sv
// Directed bench for axi_wb: FIFO/AXI slave model driven per cycle, outputs checked against hand-computed values.
module tb_axi_wb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_wb_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) bus ();

  axi_wb #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk;
  int n_fail;
  int cyc;

  logic [31:0] mem [256];
  int          wr_cnt, rd_ptr;
  int          pops, nbeats, aw_cnt, aw_cyc, aw_bad, w_bad, gap_cnt, gap_bad, gap_left;
  logic [31:0] beat_dat [256];
  logic        beat_last [256];
  logic [15:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  beat_strb_or;

  int          aw_from;
  bit          w_toggle, gap_en;
  logic [1:0]  bresp_val;

  logic        aw_wait, w_wait;
  logic [15:0] prev_awaddr;
  logic [7:0]  prev_awlen;
  logic [31:0] prev_wdata;
  logic        prev_wlast;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic knobs_default();
    aw_from   = 0;
    w_toggle  = 1'b0;
    gap_en    = 1'b0;
    gap_left  = 0;
    bresp_val = 2'b00;
  endtask

  task automatic drive();
    logic gap_now;
    gap_now = gap_en && (nbeats == 2) && (gap_left > 0);
    bus.arg_0_read_ready    = !gap_now && (rd_ptr < wr_cnt);
    bus.arg_0_out_data      = (rd_ptr < 256) ? mem[rd_ptr[7:0]] : 32'h0;
    bus.arg_3_s_axi_awready = (cyc >= aw_from);
    bus.arg_3_s_axi_wready  = w_toggle ? ((cyc % 4) >= 2) : 1'b1;
    bus.arg_3_s_axi_bvalid  = 1'b1;
    bus.arg_3_s_axi_bresp   = bresp_val;
  endtask

  task automatic tick();
    logic pop_now;
    if (gap_en && (nbeats == 2) && (gap_left > 0)) begin
      gap_cnt++;
      gap_left--;
      if (bus.arg_0_read_valid || bus.arg_3_s_axi_wvalid) gap_bad++;
    end
    if (aw_wait && (!bus.arg_3_s_axi_awvalid || bus.arg_3_s_axi_awaddr !== prev_awaddr ||
                    bus.arg_3_s_axi_awlen !== prev_awlen)) aw_bad++;
    aw_wait     = bus.arg_3_s_axi_awvalid && !bus.arg_3_s_axi_awready;
    prev_awaddr = bus.arg_3_s_axi_awaddr;
    prev_awlen  = bus.arg_3_s_axi_awlen;
    if (w_wait && (!bus.arg_3_s_axi_wvalid || bus.arg_3_s_axi_wdata !== prev_wdata ||
                   bus.arg_3_s_axi_wlast !== prev_wlast)) w_bad++;
    w_wait     = bus.arg_3_s_axi_wvalid && !bus.arg_3_s_axi_wready;
    prev_wdata = bus.arg_3_s_axi_wdata;
    prev_wlast = bus.arg_3_s_axi_wlast;
    if (bus.arg_3_s_axi_awvalid && bus.arg_3_s_axi_awready) begin
      aw_cnt++;
      aw_cyc   = cyc;
      aw_addr  = bus.arg_3_s_axi_awaddr;
      aw_len   = bus.arg_3_s_axi_awlen;
      aw_size  = bus.arg_3_s_axi_awsize;
      aw_burst = bus.arg_3_s_axi_awburst;
    end
    if (bus.arg_3_s_axi_wvalid && bus.arg_3_s_axi_wready) begin
      if (nbeats < 256) begin
        beat_dat[nbeats[7:0]]  = bus.arg_3_s_axi_wdata;
        beat_last[nbeats[7:0]] = bus.arg_3_s_axi_wlast;
      end
      beat_strb_or = beat_strb_or | ~bus.arg_3_s_axi_wstrb;
      nbeats++;
    end
    pop_now = bus.arg_0_read_valid && bus.arg_0_read_ready;
    if (pop_now) pops++;
    @(posedge clk);
    cyc++;
    if (pop_now) rd_ptr++;
    #1;
    drive();
    #1;
  endtask

  task automatic start(input logic [7:0] len, input logic [15:0] base, input int nw,
                       input logic [31:0] first);
    rst = 1'b1;
    bus.arg_1_rdata = len;
    bus.arg_2_rdata = base;
    for (int i = 0; i < 256; i++) begin
      mem[i[7:0]]       = first + 32'(i);
      beat_dat[i[7:0]]  = 32'h0;
      beat_last[i[7:0]] = 1'b0;
    end
    wr_cnt = nw;  rd_ptr = 0;  pops = 0;  nbeats = 0;  aw_cnt = 0;  aw_cyc = -1;
    aw_bad = 0;   w_bad = 0;   gap_cnt = 0;  gap_bad = 0;  aw_wait = 1'b0;  w_wait = 1'b0;
    beat_strb_or = 4'h0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    drive();
    rst = 1'b0;
    #1;
  endtask

  task automatic run(input int budget);
    while (!bus.valid && cyc < budget) tick();
  endtask

  initial begin
    int n_last;
    n_chk  = 0;
    n_fail = 0;
    knobs_default();

    // Reset state with live inputs on the bus
    start(8'd3, 16'h0100, 4, 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hs", {bus.arg_3_s_axi_awvalid, bus.arg_3_s_axi_wvalid, bus.arg_3_s_axi_bready,
                   bus.arg_0_read_valid, bus.valid, bus.error, bus.arg_3_s_axi_wlast}, 64'h0);
    chk("rst_awaddr", bus.arg_3_s_axi_awaddr, 64'h0);
    chk("rst_wdata", bus.arg_3_s_axi_wdata, 64'h0);
    chk("rst_raddr", {bus.arg_1_raddr, bus.arg_2_raddr}, 64'h0);

    // len=3, base 0x0100, data 1..4, everything ready
    start(8'd3, 16'h0100, 4, 32'd1);
    run(40);
    chk("t1_done_cyc", cyc, 11);
    chk("t1_aw_cyc", aw_cyc, 1);
    chk("t1_awaddr", aw_addr, 16'h0100);
    chk("t1_awlen", aw_len, 8'd3);
    chk("t1_awsize_burst", {aw_size, aw_burst}, {3'd2, 2'b01});
    chk("t1_beats", nbeats, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_wdata%0d", i), beat_dat[i[7:0]], 32'(i + 1));
      chk($sformatf("t1_wlast%0d", i), beat_last[i[7:0]], (i == 3) ? 1'b1 : 1'b0);
    end
    chk("t1_wstrb", beat_strb_or, 4'h0);
    chk("t1_error", bus.error, 1'b0);
    repeat (3) tick();
    chk("t1_done_hold", {bus.valid, bus.arg_3_s_axi_awvalid, bus.arg_3_s_axi_wvalid,
                         bus.arg_3_s_axi_bready, bus.arg_0_read_valid}, 5'b10000);
    chk("t1_pops", pops, 4);

    // len=0: single beat carrying wlast
    start(8'd0, 16'h0040, 3, 32'h55);
    run(30);
    repeat (2) tick();
    chk("t2_done_cyc", cyc, 7);
    chk("t2_beats", nbeats, 1);
    chk("t2_wlast", beat_last[0], 1'b1);
    chk("t2_wdata", beat_dat[0], 32'h55);
    chk("t2_pops", pops, 1);

    // awready held off 5 cycles, wready toggling
    knobs_default();
    aw_from  = 6;
    w_toggle = 1'b1;
    start(8'd3, 16'h0A00, 6, 32'h10);
    run(80);
    chk("t3_valid", bus.valid, 1'b1);
    chk("t3_aw_cyc", aw_cyc, 6);
    chk("t3_aw_stable", aw_bad, 0);
    chk("t3_w_stable", w_bad, 0);
    chk("t3_pops", pops, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_wdata%0d", i), beat_dat[i[7:0]], 32'h10 + 32'(i));

    // FIFO empty for 10 cycles between beats 2 and 3
    knobs_default();
    gap_en   = 1'b1;
    gap_left = 10;
    start(8'd3, 16'h0100, 4, 32'h21);
    run(60);
    chk("t4_done_cyc", cyc, 21);
    chk("t4_gap_cycles", gap_cnt, 10);
    chk("t4_gap_quiet", gap_bad, 0);
    chk("t4_pops", pops, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_wdata%0d", i), beat_dat[i[7:0]], 32'h21 + 32'(i));

    // SLVERR response
    knobs_default();
    bresp_val = 2'b10;
    start(8'd1, 16'h0100, 2, 32'h7);
    run(30);
    tick();
    chk("t5_done_cyc", cyc, 8);
    chk("t5_valid_error", {bus.valid, bus.error}, 2'b11);

    // len=255: 256 beats, wlast only on the final one
    knobs_default();
    start(8'd255, 16'h1000, 256, 32'h1000);
    run(600);
    n_last = 0;
    for (int i = 0; i < 256; i++) n_last += int'(beat_last[i[7:0]]);
    chk("t6_done_cyc", cyc, 515);
    chk("t6_beats", nbeats, 256);
    chk("t6_nlast", n_last, 1);
    chk("t6_last255", beat_last[255], 1'b1);
    chk("t6_data255", beat_dat[255], 32'h10FF);
    chk("t6_pops", pops, 256);

    // Reset asserted during beat 2 of an 8-beat burst
    knobs_default();
    start(8'd7, 16'h0200, 8, 32'h11);
    while (!(bus.arg_3_s_axi_wvalid && nbeats == 1) && cyc < 50) tick();
    chk("t7_in_beat2", {bus.arg_3_s_axi_wvalid, bus.arg_3_s_axi_wdata}, {1'b1, 32'h12});
    rst = 1'b1;
    #1;
    chk("t7_rst_hs", {bus.arg_3_s_axi_awvalid, bus.arg_3_s_axi_wvalid, bus.arg_3_s_axi_bready,
                      bus.arg_0_read_valid, bus.valid, bus.error, bus.arg_3_s_axi_wlast}, 64'h0);
    chk("t7_rst_wdata", bus.arg_3_s_axi_wdata, 64'h0);
    chk("t7_rst_wstrb", bus.arg_3_s_axi_wstrb, 64'h0);
    chk("t7_rst_aw", {bus.arg_3_s_axi_awaddr, bus.arg_3_s_axi_awlen}, 64'h0);
    start(8'd1, 16'h0300, 2, 32'hA1);
    run(30);
    chk("t7_done_cyc", cyc, 7);
    chk("t7_aw_cyc", aw_cyc, 1);
    chk("t7_awaddr", aw_addr, 16'h0300);
    chk("t7_awlen", aw_len, 8'd1);
    chk("t7_beats", nbeats, 2);
    chk("t7_wdata0", beat_dat[0], 32'hA1);
    chk("t7_wdata1", beat_dat[1], 32'hA2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
